tmr_input_filter: RTL



---
 rtl/tmr_pkg.sv | 29 ++
 rtl/majority_voter_err.sv | 18 +
 rtl/tmr_input_filter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared TMR definitions: replica count, defaults, bitwise majority and
// ceil-log2 helpers used to size the replicated filter state.
package tmr_pkg;

    localparam int REPLICAS         = 3;
    localparam int DEBOUNCE_DEFAULT = 4;

    // Bitwise 2-of-3 majority; callers cast to their own width.
    function automatic logic [31:0] maj3(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/majority_voter_err.sv
// Width-parameterised 2-of-3 voter with a disagreement flag.
// Ports: a/b/c replica values, voted majority, mismatch when not all equal.
module majority_voter_err
    import tmr_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] voted,
    output logic         mismatch
);

    assign voted    = W'(maj3(32'(a), 32'(b), 32'(c)));
    assign mismatch = (a != b) || (a != c);

endmodule

// File: rtl/tmr_input_filter.sv
// Triplicated synchroniser + debounce filter with full-voting feedback.
// Ports: clk, rstn (async low), in (raw async), err_clr; out (voted
// level), err (registered mismatch pulse), err_cnt (saturating count).
module tmr_input_filter
    import tmr_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int ECW      = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in,
    input  logic           err_clr,
    output logic           out,
    output logic           err,
    output logic [ECW-1:0] err_cnt
);

    localparam int CW = (clog2(DEBOUNCE) < 1) ? 1 : clog2(DEBOUNCE);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic          sync1A, sync1B, sync1C;
    logic          sync2A, sync2B, sync2C;
    logic          filtA, filtB, filtC;
    logic [CW-1:0] cntA, cntB, cntC;

    logic          filtV;
    logic [CW-1:0] cntV;
    logic          filtMis;
    logic          cntMis;

    majority_voter_err #(.W(1)) uFiltVote (
        .a        (filtA),
        .b        (filtB),
        .c        (filtC),
        .voted    (filtV),
        .mismatch (filtMis)
    );

    majority_voter_err #(.W(CW)) uCntVote (
        .a        (cntA),
        .b        (cntB),
        .c        (cntC),
        .voted    (cntV),
        .mismatch (cntMis)
    );

    // Every replica advances from the voted state, so a corrupted
    // replica is overwritten with the majority view on the next edge.
    function automatic logic [CW:0] nextRep(
        input logic          s,
        input logic          fv,
        input logic [CW-1:0] cv
    );
        if (s == fv) begin
            return {fv, {CW{1'b0}}};
        end else if (cv == CNT_LAST) begin
            return {s, {CW{1'b0}}};
        end else begin
            return {fv, cv + CW'(1)};
        end
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1A <= 1'b0;
            sync2A <= 1'b0;
            filtA  <= 1'b0;
            cntA   <= '0;
        end else begin
            sync1A        <= in;
            sync2A        <= sync1A;
            {filtA, cntA} <= nextRep(sync2A, filtV, cntV);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1B <= 1'b0;
            sync2B <= 1'b0;
            filtB  <= 1'b0;
            cntB   <= '0;
        end else begin
            sync1B        <= in;
            sync2B        <= sync1B;
            {filtB, cntB} <= nextRep(sync2B, filtV, cntV);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1C <= 1'b0;
            sync2C <= 1'b0;
            filtC  <= 1'b0;
            cntC   <= '0;
        end else begin
            sync1C        <= in;
            sync2C        <= sync1C;
            {filtC, cntC} <= nextRep(sync2C, filtV, cntV);
        end
    end

    // Synchroniser stages may legitimately disagree, so only the
    // filter state takes part in error detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= filtMis | cntMis;
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err && (err_cnt != {ECW{1'b1}})) begin
                err_cnt <= err_cnt + ECW'(1);
            end
        end
    end

    assign out = filtV;

endmodule
